// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, functs,
// ALU encodings, FSM states and datapath mux selects.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_INVALID
  } inst_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SGT = 6'h29;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SGT  = 4'b1001;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  function automatic inst_class_t classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                  return CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: return CLS_IALU;
      OP_LW:                                     return CLS_LOAD;
      OP_SW:                                     return CLS_STORE;
      OP_BEQ, OP_BNE:                            return CLS_BRANCH;
      OP_J, OP_JAL:                              return CLS_JUMP;
      default:                                   return CLS_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/mcu_alu_decode.sv
// Combinational ALU-function decode: instruction class + opcode/funct to
// alu_op, A-operand select and a validity flag.
module mcu_alu_decode
  import multicycle_control_unit_pkg::*;
(
  input  inst_class_t cls,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic        is_valid
);

  always_comb begin
    alu_op    = ALU_NONE;
    alu_src_a = SRCA_RS;
    is_valid  = 1'b1;
    case (cls)
      CLS_RTYPE: begin
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SGT: alu_op = ALU_SGT;
          FN_XOR: alu_op = ALU_XOR;
          FN_NOR: alu_op = ALU_NOR;
          FN_SLL: begin
            alu_op    = ALU_SLL;
            alu_src_a = SRCA_SHAMT;
          end
          FN_SRL: begin
            alu_op    = ALU_SRL;
            alu_src_a = SRCA_SHAMT;
          end
          FN_JR:   alu_op = ALU_NONE;
          default: is_valid = 1'b0;
        endcase
      end
      CLS_IALU: begin
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_XORI: alu_op = ALU_XOR;
          OP_SLTI: alu_op = ALU_SLT;
          default: is_valid = 1'b0;
        endcase
      end
      CLS_LOAD, CLS_STORE: alu_op = ALU_ADD;
      CLS_BRANCH:          alu_op = ALU_SUB;
      CLS_JUMP:            alu_op = ALU_NONE;
      default:             is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with a shared ALU, unified memory port with
// wait states, and sticky traps for invalid instructions / memory timeout.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr_en,
  output logic               ir_wr_en,
  output logic               i_or_d,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_wr_en,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               invalid_inst,
  output logic               mem_timeout,
  output logic               busy
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [TMR_W-1:0] wait_cnt;
  inst_class_t      cls;
  logic             is_jr;
  logic             in_mem_state;
  logic             mem_expire;
  logic [3:0]       dec_alu_op;
  logic [1:0]       dec_src_a;
  logic             dec_valid;
  logic [3:0]       alu_code;

  assign cls          = classify(opcode);
  assign is_jr        = (cls == CLS_RTYPE) && (funct == FN_JR);
  assign in_mem_state = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // A ready arriving in the last allowed cycle completes normally.
  assign mem_expire   = in_mem_state && !mem_ready && (wait_cnt == TMO_LAST);

  mcu_alu_decode u_alu_decode (
    .cls       (cls),
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .is_valid  (dec_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      invalid_inst <= 1'b0;
      mem_timeout  <= 1'b0;
    end else begin
      if (in_mem_state && !mem_ready) wait_cnt <= wait_cnt + TMR_W'(1);
      else                            wait_cnt <= '0;

      if (mem_expire) begin
        state       <= S_TRAP;
        mem_timeout <= 1'b1;
      end else begin
        case (state)
          S_FETCH: if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            if (!dec_valid) begin
              state        <= S_TRAP;
              invalid_inst <= 1'b1;
            end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
              state <= S_MEM_ADDR;
            end else if (cls == CLS_JUMP || is_jr) begin
              state <= S_JUMP;
            end else begin
              state <= S_EXEC;
            end
          end
          S_EXEC:     state <= (cls == CLS_BRANCH) ? S_FETCH : S_WB;
          S_MEM_ADDR: state <= (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD:   if (mem_ready) state <= S_WB;
          S_MEM_WR:   if (mem_ready) state <= S_FETCH;
          S_WB:       state <= S_FETCH;
          S_JUMP:     state <= S_FETCH;
          S_TRAP:     state <= S_TRAP;
          default:    state <= S_FETCH;
        endcase
      end
    end
  end

  // Outputs are gated by reset so an aborted access never issues a write.
  always_comb begin
    pc_wr_en   = 1'b0;
    ir_wr_en   = 1'b0;
    i_or_d     = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    reg_dst    = RDST_RT;
    mem_to_reg = M2R_ALUOUT;
    reg_wr_en  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RT;
    alu_code   = ALU_NONE;
    pc_src     = PCSRC_ALU;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_rd_en = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_code  = ALU_ADD;
          if (mem_ready) begin
            ir_wr_en = 1'b1;
            pc_wr_en = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          alu_code  = ALU_ADD;
        end
        S_EXEC: begin
          alu_src_a = dec_src_a;
          alu_code  = dec_alu_op;
          if (cls == CLS_IALU) alu_src_b = SRCB_IMM;
          if (cls == CLS_BRANCH) begin
            pc_src   = PCSRC_ALUOUT;
            pc_wr_en = (opcode == OP_BEQ) ? zero : ~zero;
          end
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS;
          alu_src_b = SRCB_IMM;
          alu_code  = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_rd_en = 1'b1;
          i_or_d    = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr_en = 1'b1;
          i_or_d    = 1'b1;
        end
        S_WB: begin
          reg_wr_en = 1'b1;
          if (cls == CLS_RTYPE) reg_dst = RDST_RD;
          if (cls == CLS_LOAD)  mem_to_reg = M2R_MDR;
        end
        S_JUMP: begin
          pc_wr_en = 1'b1;
          pc_src   = is_jr ? PCSRC_RS : PCSRC_JUMP;
          if (opcode == OP_JAL) begin
            reg_wr_en  = 1'b1;
            reg_dst    = RDST_RA;
            mem_to_reg = M2R_PC;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(alu_code);
  assign busy   = !reset && (state != S_TRAP);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit: per-cycle output vectors
// compared against hand-derived expectations.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_wr_en, ir_wr_en, i_or_d, mem_rd_en, mem_wr_en, reg_wr_en;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_op;
  logic       invalid_inst, mem_timeout, busy;

  int checks = 0;
  int errors = 0;
  logic [22:0] obs, exp;
  logic [22:0] f_rdy, f_wait, dec, rstv, ex_add, wb_r, wb_i, trap_inv, trap_mto;

  multicycle_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(15), .TMR_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr_en(pc_wr_en), .ir_wr_en(ir_wr_en),
    .i_or_d(i_or_d), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr_en(reg_wr_en),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .invalid_inst(invalid_inst), .mem_timeout(mem_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {pc_wr_en, ir_wr_en, i_or_d, mem_rd_en, mem_wr_en, reg_dst, mem_to_reg,
                reg_wr_en, alu_src_a, alu_src_b, alu_op, pc_src, invalid_inst,
                mem_timeout, busy};

  function automatic logic [22:0] ov(input logic pcw, irw, iord, mrd, mwr,
                                     input logic [1:0] rdst, m2r, input logic rwr,
                                     input logic [1:0] sa, sb, input logic [3:0] aop,
                                     input logic [1:0] ps, input logic inv, mto, bsy);
    return {pcw, irw, iord, mrd, mwr, rdst, m2r, rwr, sa, sb, aop, ps, inv, mto, bsy};
  endfunction

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy);
    @(negedge clk);
    opcode = op; funct = fn; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== rstv) begin errors++; $display("FAIL reset_outputs got=%h want=%h", obs, rstv); end
    release_reset();
  endtask

  task automatic test_add();
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL add_fetch got=%h want=%h", obs, f_rdy); end
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== dec) begin errors++; $display("FAIL add_decode got=%h want=%h", obs, dec); end
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== ex_add) begin errors++; $display("FAIL add_exec got=%h want=%h", obs, ex_add); end
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== wb_r) begin errors++; $display("FAIL add_wb got=%h want=%h", obs, wb_r); end
  endtask

  task automatic test_ialu_shift();
    cyc(6'h0D, 6'h25, 0, 1); cyc(6'h0D, 6'h25, 0, 1);
    cyc(6'h0D, 6'h25, 0, 1);
    exp = ov(0,0,0,0,0,2'b00,2'b00,0,2'b01,2'b10,4'b0011,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL ori_exec got=%h want=%h", obs, exp); end
    cyc(6'h0D, 6'h25, 0, 1); checks++;
    if (obs !== wb_i) begin errors++; $display("FAIL ori_wb got=%h want=%h", obs, wb_i); end
    cyc(6'h00, 6'h00, 0, 1); cyc(6'h00, 6'h00, 0, 1);
    cyc(6'h00, 6'h00, 0, 1);
    exp = ov(0,0,0,0,0,2'b00,2'b00,0,2'b10,2'b00,4'b0111,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sll_exec got=%h want=%h", obs, exp); end
    cyc(6'h00, 6'h00, 0, 1);
    cyc(6'h00, 6'h29, 0, 1); cyc(6'h00, 6'h29, 0, 1);
    cyc(6'h00, 6'h29, 0, 1);
    exp = ov(0,0,0,0,0,2'b00,2'b00,0,2'b01,2'b00,4'b1001,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sgt_exec got=%h want=%h", obs, exp); end
    cyc(6'h00, 6'h29, 0, 1); checks++;
    if (obs !== wb_r) begin errors++; $display("FAIL sgt_wb got=%h want=%h", obs, wb_r); end
  endtask

  task automatic test_lw_wait();
    cyc(6'h23, 6'h00, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL lw_fetch got=%h want=%h", obs, f_rdy); end
    cyc(6'h23, 6'h00, 0, 1);
    cyc(6'h23, 6'h00, 0, 1);
    exp = ov(0,0,0,0,0,2'b00,2'b00,0,2'b01,2'b10,4'b0000,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lw_memaddr got=%h want=%h", obs, exp); end
    exp = ov(0,0,1,1,0,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b00,0,0,1);
    for (int i = 0; i < 3; i++) begin
      cyc(6'h23, 6'h00, 0, (i == 2));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL lw_memrd%0d got=%h want=%h", i, obs, exp); end
    end
    cyc(6'h23, 6'h00, 0, 1);
    exp = ov(0,0,0,0,0,2'b00,2'b01,1,2'b00,2'b00,4'b1111,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lw_wb got=%h want=%h", obs, exp); end
  endtask

  task automatic test_sw();
    cyc(6'h2B, 6'h00, 0, 1); cyc(6'h2B, 6'h00, 0, 1); cyc(6'h2B, 6'h00, 0, 1);
    cyc(6'h2B, 6'h00, 0, 1);
    exp = ov(0,0,1,0,1,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sw_memwr got=%h want=%h", obs, exp); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'h04, 6'h05, 6'h05};
    logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
    logic       pcw [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      cyc(ops[i], 6'h00, zs[i], 1); checks++;
      if (obs !== f_rdy) begin errors++; $display("FAIL br%0d_fetch got=%h want=%h", i, obs, f_rdy); end
      cyc(ops[i], 6'h00, zs[i], 1);
      cyc(ops[i], 6'h00, zs[i], 1);
      exp = ov(pcw[i],0,0,0,0,2'b00,2'b00,0,2'b01,2'b00,4'b0001,2'b01,0,0,1); checks++;
      if (obs !== exp) begin errors++; $display("FAIL br%0d_exec got=%h want=%h", i, obs, exp); end
    end
  endtask

  task automatic test_jump();
    cyc(6'h03, 6'h00, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL jal_fetch got=%h want=%h", obs, f_rdy); end
    cyc(6'h03, 6'h00, 0, 1); cyc(6'h03, 6'h00, 0, 1);
    exp = ov(1,0,0,0,0,2'b10,2'b10,1,2'b00,2'b00,4'b1111,2'b10,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL jal_jump got=%h want=%h", obs, exp); end
    cyc(6'h00, 6'h08, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL jr_fetch got=%h want=%h", obs, f_rdy); end
    cyc(6'h00, 6'h08, 0, 1); cyc(6'h00, 6'h08, 0, 1);
    exp = ov(1,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b11,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL jr_jump got=%h want=%h", obs, exp); end
    cyc(6'h02, 6'h00, 0, 1); cyc(6'h02, 6'h00, 0, 1); cyc(6'h02, 6'h00, 0, 1);
    exp = ov(1,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b10,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL j_jump got=%h want=%h", obs, exp); end
  endtask

  task automatic test_timeout_boundary();
    for (int i = 0; i < 14; i++) begin
      cyc(6'h00, 6'h20, 0, 0); checks++;
      if (obs !== f_wait) begin errors++; $display("FAIL tmo_edge_wait%0d got=%h want=%h", i, obs, f_wait); end
    end
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL tmo_edge_ready got=%h want=%h", obs, f_rdy); end
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== dec) begin errors++; $display("FAIL tmo_edge_decode got=%h want=%h", obs, dec); end
    cyc(6'h00, 6'h20, 0, 1); cyc(6'h00, 6'h20, 0, 1);
  endtask

  task automatic test_timeout_trap();
    for (int i = 0; i < 15; i++) begin
      cyc(6'h00, 6'h20, 0, 0); checks++;
      if (obs !== f_wait) begin errors++; $display("FAIL tmo_wait%0d got=%h want=%h", i, obs, f_wait); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(6'h00, 6'h20, 0, (i != 0)); checks++;
      if (obs !== trap_mto) begin errors++; $display("FAIL tmo_trap%0d got=%h want=%h", i, obs, trap_mto); end
    end
  endtask

  task automatic test_invalid(input logic [5:0] op, input logic [5:0] fn);
    cyc(op, fn, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL inv_fetch got=%h want=%h", obs, f_rdy); end
    cyc(op, fn, 0, 1); checks++;
    if (obs !== dec) begin errors++; $display("FAIL inv_decode got=%h want=%h", obs, dec); end
    for (int i = 0; i < 4; i++) begin
      cyc(op, fn, 1, 1); checks++;
      if (obs !== trap_inv) begin errors++; $display("FAIL inv_trap%0d got=%h want=%h", i, obs, trap_inv); end
    end
  endtask

  task automatic test_reset_clears();
    @(negedge clk);
    reset = 1'b1;
    #1; checks++;
    if (obs !== rstv) begin errors++; $display("FAIL reset_clear got=%h want=%h", obs, rstv); end
    release_reset();
  endtask

  task automatic test_reset_mid_write();
    cyc(6'h2B, 6'h00, 0, 1); cyc(6'h2B, 6'h00, 0, 1); cyc(6'h2B, 6'h00, 0, 1);
    cyc(6'h2B, 6'h00, 0, 0);
    exp = ov(0,0,1,0,1,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b00,0,0,1); checks++;
    if (obs !== exp) begin errors++; $display("FAIL midwr_before got=%h want=%h", obs, exp); end
    reset = 1'b1;
    #1; checks++;
    if (obs !== rstv) begin errors++; $display("FAIL midwr_abort got=%h want=%h", obs, rstv); end
    release_reset();
    cyc(6'h00, 6'h20, 0, 1); checks++;
    if (obs !== f_rdy) begin errors++; $display("FAIL midwr_refetch got=%h want=%h", obs, f_rdy); end
  endtask

  initial begin
    f_rdy    = ov(1,1,0,1,0,2'b00,2'b00,0,2'b00,2'b01,4'b0000,2'b00,0,0,1);
    f_wait   = ov(0,0,0,1,0,2'b00,2'b00,0,2'b00,2'b01,4'b0000,2'b00,0,0,1);
    dec      = ov(0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b11,4'b0000,2'b00,0,0,1);
    rstv     = ov(0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b00,0,0,0);
    ex_add   = ov(0,0,0,0,0,2'b00,2'b00,0,2'b01,2'b00,4'b0000,2'b00,0,0,1);
    wb_r     = ov(0,0,0,0,0,2'b01,2'b00,1,2'b00,2'b00,4'b1111,2'b00,0,0,1);
    wb_i     = ov(0,0,0,0,0,2'b00,2'b00,1,2'b00,2'b00,4'b1111,2'b00,0,0,1);
    trap_inv = ov(0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b00,1,0,0);
    trap_mto = ov(0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,4'b1111,2'b00,0,1,0);

    test_reset();
    test_add();
    test_ialu_shift();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_timeout_boundary();
    test_timeout_trap();
    test_reset_clears();
    test_invalid(6'h3F, 6'h20);
    test_reset_clears();
    test_invalid(6'h00, 6'h3F);
    test_reset_clears();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
